io_responder: RTL and testbench
===============================

# io_responder

Memory-mapped IO responder for the single-cycle CPU. It answers CPU loads and stores in the IO window (address bit 15 set) using the codebase's IO address map, and holds the sort-status, lamp, LED-control and LED-nibble registers. It also synchronizes the front-panel START/CE/CP/CH switches and runs the sort cycle counter. It sits between the CPU data-memory port and the board IO/LED display logic.

## Interface
- DATA_WIDTH, 32, CPU data width
- ADDR_WIDTH, 16, CPU data address width
- CYCLE_WIDTH, 32, cycle counter width
- LED_IN_WIDTH, 4, width of one LED nibble register
- LAMP_WIDTH, 8, lamp register width
- SYNC_STAGES, 2, switch synchronizer depth
- clk  in  1  single clock
- rst  in  1  reset, synchronous, active-high
- addr  in  ADDR_WIDTH  CPU data address; IO selected when addr[15]=1; register index = addr[6:2]
- wrEn  in  1  CPU store strobe
- rdEn  in  1  CPU load strobe (drives read side effects only)
- wrData  in  DATA_WIDTH  store data
- rdData  out  DATA_WIDTH  load data, combinational
- sortStartIn, ceIn, cpIn, chIn  in  1 each  raw asynchronous switches
- sortFinished  out  1  finish flag
- sortCount  out  DATA_WIDTH  software-written sort count
- lamp  out  LAMP_WIDTH  lamp register
- ledCtrl  out  1  0 = show cycle/sort result, 1 = show user LED registers
- ledOut  out  8*LED_IN_WIDTH  LED nibbles; LEDk is at [4k+:4]
- cycleCount  out  CYCLE_WIDTH  sort cycle counter

## Operation
- Writes take effect at clk when wrEn=1 and addr[15]=1:
  - idx 0x00: sortFinished ← wrData[0]
  - idx 0x01: sortCount ← wrData
  - idx 0x02: lamp ← wrData[7:0]
  - idx 0x03: ledCtrl ← wrData[0]
  - idx 0x08–0x0F: LED(idx−8) ← wrData[3:0]
  - All other indices are read-only or unmapped. Writes to them are ignored.
- Reads are combinational, zero-extended, and valid whenever addr[15]=1, independent of rdEn:
  - 0x00 sortFinished; 0x01 sortCount; 0x02 lamp; 0x03 ledCtrl; 0x08–0x0F LED nibble
  - 0x10 startPending; 0x11/0x12/0x13 synced CE/CP/CH level; 0x14 cycleCount
  - Unmapped indices, including the OLED range 0x15+, read 0.
  - When addr[15]=0, rdData=0.
- Switches: each passes through a SYNC_STAGES flop chain. START additionally has a rising-edge detector (sync output versus its one-cycle-delayed copy).
- startPending:
  - Set on a START rising edge.
  - Cleared at clk when rdEn=1, addr[15]=1 and idx=0x10. The read returns the pre-clear value.
  - If an edge and a clear happen in the same cycle, set wins.
- Cycle FSM (IDLE, RUNNING, DONE):
  - IDLE → RUNNING on a START edge; cycleCount ← 0.
  - RUNNING: cycleCount increments by 1 per clk and saturates at all-ones. RUNNING → DONE on a write to idx 0x00 with wrData[0]=1; on that edge the counter holds (no increment).
  - DONE: cycleCount holds. DONE → RUNNING on a START edge, with cycleCount ← 0.
  - A finish write with wrData[0]=0 does not change FSM state.
  - START edge and finish write in the same RUNNING cycle: finish wins (→ DONE). startPending is still set.
  - A START edge while RUNNING is ignored by the FSM but still sets startPending.

## Timing
- Reset: every output register, startPending, the synchronizer flops and the edge-delay flop are cleared to 0; FSM goes to IDLE. Consequently rdData reads 0 for all indices after reset.
- Write to register output: the register output changes after the write edge (1 cycle).
- Read data: same cycle, no latency.
- Switch latency: raw input stable high before edge N gives synced level 1 after edge N+1 (readable from then). For START, the edge detector fires and startPending=1 and FSM=RUNNING after edge N+2.
- Reset mid-count: the next clk with rst=1 forces IDLE and clears the counter. A pending START edge is lost.

## Test plan
- Reset, then read indices 0x00–0x1F (addr 0x8000–0x807C) → all 0; sortFinished, ledCtrl, ledOut and cycleCount are 0.
- Store 0xABCD1235 to 0x8020 and 0x0000000F to 0x803C → ledOut = 0xF0000005. Store 0xFFFFFFFF to 0x8004 → sortCount = 0xFFFFFFFF. Store to 0x8050 → cycleCount unchanged.
- Pulse sortStartIn high at edge N → startPending=1 after N+2. Ten clocks later read 0x8050 → 10. Load from 0x8040 with rdEn returns 1; the next read returns 0.
- While RUNNING, store 1 to 0x8000 → FSM DONE and cycleCount frozen for 100 cycles. A new START edge → counter restarts from 0.
- Assert a START edge and a finish write in the same cycle while RUNNING → FSM DONE and startPending=1. A START edge coincident with a clear read → startPending stays 1.
- Preload the counter near saturation (via a bench force) → counter stops at 0xFFFFFFFF. Assert rst mid-RUNNING → IDLE and count 0 after one edge.

Source files
------------

// File: rtl/io_responder.sv
// IO window responder for the single-cycle CPU: status/lamp/LED registers,
// front-panel switch synchronizers and the sort cycle counter.
module io_responder #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int CYCLE_WIDTH  = 32,
  parameter int LED_IN_WIDTH = 4,
  parameter int LAMP_WIDTH   = 8,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [ADDR_WIDTH-1:0]     addr_i,
  input  logic                      wrEn_i,
  input  logic                      rdEn_i,
  input  logic [DATA_WIDTH-1:0]     wrData_i,
  output logic [DATA_WIDTH-1:0]     rdData_o,
  input  logic                      sortStartIn_i,
  input  logic                      ceIn_i,
  input  logic                      cpIn_i,
  input  logic                      chIn_i,
  output logic                      sortFinished_o,
  output logic [DATA_WIDTH-1:0]     sortCount_o,
  output logic [LAMP_WIDTH-1:0]     lamp_o,
  output logic                      ledCtrl_o,
  output logic [8*LED_IN_WIDTH-1:0] ledOut_o,
  output logic [CYCLE_WIDTH-1:0]    cycleCount_o
);

  typedef enum logic [1:0] {IDLE, RUNNING, DONE} cycleState_e;

  localparam logic [4:0] IDX_FINISH  = 5'h00;
  localparam logic [4:0] IDX_COUNT   = 5'h01;
  localparam logic [4:0] IDX_LAMP    = 5'h02;
  localparam logic [4:0] IDX_LEDCTRL = 5'h03;
  localparam logic [4:0] IDX_PENDING = 5'h10;
  localparam logic [4:0] IDX_CE      = 5'h11;
  localparam logic [4:0] IDX_CP      = 5'h12;
  localparam logic [4:0] IDX_CH      = 5'h13;
  localparam logic [4:0] IDX_CYCLE   = 5'h14;

  logic                    ioSel;
  logic [4:0]              idx;
  logic                    wrSel;
  logic                    finishWr;
  logic                    pendingClr;
  logic                    startEdge;
  logic [3:0]              rawSw;
  logic [3:0]              swLevel;
  logic [SYNC_STAGES-1:0]  sync_q [4];
  logic                    startDly_q;
  logic                    startPending_q;
  logic                    startPending_d;
  logic                    sortFinished_q;
  logic [DATA_WIDTH-1:0]   sortCount_q;
  logic [LAMP_WIDTH-1:0]   lamp_q;
  logic                    ledCtrl_q;
  logic [LED_IN_WIDTH-1:0] led_q [8];
  cycleState_e             state_q;
  logic [CYCLE_WIDTH-1:0]  cycleCount_q;
  logic                    unusedAddrBits;

  assign ioSel      = addr_i[15];
  assign idx        = addr_i[6:2];
  assign wrSel      = wrEn_i & ioSel;
  assign finishWr   = wrSel && (idx == IDX_FINISH) && wrData_i[0];
  assign pendingClr = rdEn_i && ioSel && (idx == IDX_PENDING);
  assign rawSw      = {chIn_i, cpIn_i, ceIn_i, sortStartIn_i};
  assign startEdge  = swLevel[0] & ~startDly_q;
  assign unusedAddrBits = ^{addr_i[14:7], addr_i[1:0]};

  always_comb begin
    swLevel = '0;
    for (int i = 0; i < 4; i++) swLevel[i] = sync_q[i][SYNC_STAGES-1];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 4; i++) sync_q[i] <= '0;
      startDly_q <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], rawSw[i]};
      startDly_q <= swLevel[0];
    end
  end

  // A new START edge outranks a same-cycle clearing read so no start is dropped.
  always_comb begin
    startPending_d = startPending_q;
    if (startEdge)       startPending_d = 1'b1;
    else if (pendingClr) startPending_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      startPending_q <= 1'b0;
      sortFinished_q <= 1'b0;
      sortCount_q    <= '0;
      lamp_q         <= '0;
      ledCtrl_q      <= 1'b0;
      for (int k = 0; k < 8; k++) led_q[k] <= '0;
    end else begin
      startPending_q <= startPending_d;
      if (wrSel) begin
        case (idx)
          IDX_FINISH:  sortFinished_q <= wrData_i[0];
          IDX_COUNT:   sortCount_q    <= wrData_i;
          IDX_LAMP:    lamp_q         <= wrData_i[LAMP_WIDTH-1:0];
          IDX_LEDCTRL: ledCtrl_q      <= wrData_i[0];
          default: begin
            if (idx[4:3] == 2'b01) led_q[idx[2:0]] <= wrData_i[LED_IN_WIDTH-1:0];
          end
        endcase
      end
    end
  end

  // Finish write wins over a coincident START edge; the counter holds on that edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cycleCount_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (startEdge) begin
            state_q      <= RUNNING;
            cycleCount_q <= '0;
          end
        end
        RUNNING: begin
          if (finishWr)               state_q      <= DONE;
          else if (cycleCount_q != '1) cycleCount_q <= cycleCount_q + CYCLE_WIDTH'(1);
        end
        DONE: begin
          if (startEdge) begin
            state_q      <= RUNNING;
            cycleCount_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    ledOut_o = '0;
    for (int k = 0; k < 8; k++) ledOut_o[k*LED_IN_WIDTH +: LED_IN_WIDTH] = led_q[k];
  end

  always_comb begin
    rdData_o = '0;
    if (ioSel) begin
      case (idx)
        IDX_FINISH:  rdData_o = DATA_WIDTH'(sortFinished_q);
        IDX_COUNT:   rdData_o = sortCount_q;
        IDX_LAMP:    rdData_o = DATA_WIDTH'(lamp_q);
        IDX_LEDCTRL: rdData_o = DATA_WIDTH'(ledCtrl_q);
        IDX_PENDING: rdData_o = DATA_WIDTH'(startPending_q);
        IDX_CE:      rdData_o = DATA_WIDTH'(swLevel[1]);
        IDX_CP:      rdData_o = DATA_WIDTH'(swLevel[2]);
        IDX_CH:      rdData_o = DATA_WIDTH'(swLevel[3]);
        IDX_CYCLE:   rdData_o = DATA_WIDTH'(cycleCount_q);
        default: begin
          if (idx[4:3] == 2'b01) rdData_o = DATA_WIDTH'(led_q[idx[2:0]]);
        end
      endcase
    end
  end

  assign sortFinished_o = sortFinished_q;
  assign sortCount_o    = sortCount_q;
  assign lamp_o         = lamp_q;
  assign ledCtrl_o      = ledCtrl_q;
  assign cycleCount_o   = cycleCount_q;

endmodule

// File: tb/tb_io_responder.sv
// Scoreboard bench for io_responder: expected values are queued at stimulus
// time and popped when the matching DUT output is sampled.
module tb_io_responder;

  logic        clk;
  logic        rst;
  logic [15:0] addr;
  logic        wrEn;
  logic        rdEn;
  logic [31:0] wrData;
  logic [31:0] rdData;
  logic        sortStartIn;
  logic        ceIn;
  logic        cpIn;
  logic        chIn;
  logic        sortFinished;
  logic [31:0] sortCount;
  logic [7:0]  lamp;
  logic        ledCtrl;
  logic [31:0] ledOut;
  logic [31:0] cycleCount;

  logic [31:0] expQ[$];
  logic [31:0] got;
  logic [31:0] exp;
  int          checkCount;
  int          passCount;

  io_responder dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .addr_i         (addr),
    .wrEn_i         (wrEn),
    .rdEn_i         (rdEn),
    .wrData_i       (wrData),
    .rdData_o       (rdData),
    .sortStartIn_i  (sortStartIn),
    .ceIn_i         (ceIn),
    .cpIn_i         (cpIn),
    .chIn_i         (chIn),
    .sortFinished_o (sortFinished),
    .sortCount_o    (sortCount),
    .lamp_o         (lamp),
    .ledCtrl_o      (ledCtrl),
    .ledOut_o       (ledOut),
    .cycleCount_o   (cycleCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [15:0] a, input logic [31:0] d);
    addr = a; wrData = d; wrEn = 1'b1;
    tick();
    wrEn = 1'b0; wrData = '0; addr = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      expQ.push_back(32'h0);
      addr = 16'h8000 | 16'(i << 2);
      #1;
      got = rdData; exp = expQ.pop_front(); checkCount++;
      if (got !== exp) $display("[TB] FAIL reset_read idx %0d: got %h expected %h", i, got, exp);
      else passCount++;
    end
    expQ.push_back(32'h0);
    got = {sortFinished, ledCtrl, 30'h0} | ledOut | cycleCount; exp = expQ.pop_front(); checkCount++;
    if (got !== exp) $display("[TB] FAIL reset_outputs: got %h expected %h", got, exp);
    else passCount++;
  endtask

  task automatic test_writes();
    logic [15:0] rdAddr [4];
    logic [31:0] rdExp  [4];
    store(16'h8020, 32'hABCD1235);
    store(16'h803C, 32'h0000000F);
    expQ.push_back(32'hF0000005);
    got = ledOut; exp = expQ.pop_front(); checkCount++;
    if (got !== exp) $display("[TB] FAIL led_out: got %h expected %h", got, exp);
    else passCount++;

    store(16'h8004, 32'hFFFFFFFF);
    expQ.push_back(32'hFFFFFFFF);
    got = sortCount; exp = expQ.pop_front(); checkCount++;
    if (got !== exp) $display("[TB] FAIL sort_count: got %h expected %h", got, exp);
    else passCount++;

    store(16'h8008, 32'h123456A5);
    expQ.push_back(32'h000000A5);
    got = 32'(lamp); exp = expQ.pop_front(); checkCount++;
    if (got !== exp) $display("[TB] FAIL lamp: got %h expected %h", got, exp);
    else passCount++;

    store(16'h800C, 32'h00000003);
    store(16'h8050, 32'h12345678);
    store(16'h8010, 32'hFFFFFFFF);
    store(16'h0000, 32'h00000001);
    expQ.push_back(32'h0000_0002);
    got = {30'h0, ledCtrl, sortFinished} | cycleCount; exp = expQ.pop_front(); checkCount++;
    if (got !== exp) $display("[TB] FAIL ctrl_finish_cycle: got %h expected %h", got, exp);
    else passCount++;

    rdAddr = '{16'h8020, 16'h803C, 16'h0004, 16'h8010};
    rdExp  = '{32'h5, 32'hF, 32'h0, 32'h0};
    for (int i = 0; i < 4; i++) begin
      expQ.push_back(rdExp[i]);
      addr = rdAddr[i];
      #1;
      got = rdData; exp = expQ.pop_front(); checkCount++;
      if (got !== exp) $display("[TB] FAIL write_readback %h: got %h expected %h", rdAddr[i], got, exp);
      else passCount++;
    end
  endtask

  task automatic test_sync();
    ceIn = 1'b1;
    tick();
    expQ.push_back(32'h0);
    addr = 16'h8044; #1;
    got = rdData; exp = expQ.pop_front(); checkCount++;
    if (got !== exp) $display("[TB] FAIL ce_early: got %h expected %h", got, exp);
    else passCount++;
    tick();
    expQ.push_back(32'h1);
    got = rdData; exp = expQ.pop_front(); checkCount++;
    if (got !== exp) $display("[TB] FAIL ce_level: got %h expected %h", got, exp);
    else passCount++;
    cpIn = 1'b1; chIn = 1'b1;
    tick(); tick();
    for (int i = 0; i < 2; i++) begin
      expQ.push_back(32'h1);
      addr = (i == 0) ? 16'h8048 : 16'h804C;
      #1;
      got = rdData; exp = expQ.pop_front(); checkCount++;
      if (got !== exp) $display("[TB] FAIL cp_ch_level %0d: got %h expected %h", i, got, exp);
      else passCount++;
    end
    ceIn = 1'b0; cpIn = 1'b0; chIn = 1'b0;
    tick(); tick();
    expQ.push_back(32'h0);
    addr = 16'h8044; #1;
    got = rdData; exp = expQ.pop_front(); checkCount++;
    if (got !== exp) $display("[TB] FAIL ce_low: got %h expected %h", got, exp);
    else passCount++;
  endtask

  task automatic test_start();
    sortStartIn = 1'b1;
    tick();
    sortStartIn = 1'b0;
    tick();
    expQ.push_back(32'h0);
    addr = 16'h8040; #1;
    got = rdData; exp = expQ.pop_front(); checkCount++;
    if (got !== exp) $display("[TB] FAIL pending_early: got %h expected %h", got, exp);
    else passCount++;
    tick();
    expQ.push_back(32'h1);
    got = rdData; exp = expQ.pop_front(); checkCount++;
    if (got !== exp) $display("[TB] FAIL pending_set: got %h expected %h", got, exp);
    else passCount++;
    repeat (10) tick();
    expQ.push_back(32'd10);
    addr = 16'h8050; #1;
    got = rdData; exp = expQ.pop_front(); checkCount++;
    if (got !== exp) $display("[TB] FAIL count_10: got %h expected %h", got, exp);
    else passCount++;
    expQ.push_back(32'h1);
    addr = 16'h8040; rdEn = 1'b1; #1;
    got = rdData; exp = expQ.pop_front(); checkCount++;
    if (got !== exp) $display("[TB] FAIL clear_read: got %h expected %h", got, exp);
    else passCount++;
    tick();
    rdEn = 1'b0;
    expQ.push_back(32'h0);
    got = rdData; exp = expQ.pop_front(); checkCount++;
    if (got !== exp) $display("[TB] FAIL pending_cleared: got %h expected %h", got, exp);
    else passCount++;
  endtask

  task automatic test_finish();
    store(16'h8000, 32'h000000FE);
    expQ.push_back(32'd12);
    got = cycleCount | 32'(sortFinished); exp = expQ.pop_front(); checkCount++;
    if (got !== exp) $display("[TB] FAIL finish_zero: got %h expected %h", got, exp);
    else passCount++;
    store(16'h8000, 32'h00000001);
    expQ.push_back(32'd13);
    got = cycleCount | 32'(sortFinished); exp = expQ.pop_front(); checkCount++;
    if (got !== exp) $display("[TB] FAIL finish_hold: got %h expected %h", got, exp);
    else passCount++;
    repeat (100) tick();
    expQ.push_back(32'd12);
    addr = 16'h8050; #1;
    got = rdData; exp = expQ.pop_front(); checkCount++;
    if (got !== exp) $display("[TB] FAIL done_frozen: got %h expected %h", got, exp);
    else passCount++;
    sortStartIn = 1'b1;
    tick();
    sortStartIn = 1'b0;
    tick();
    tick();
    expQ.push_back(32'd0);
    got = cycleCount; exp = expQ.pop_front(); checkCount++;
    if (got !== exp) $display("[TB] FAIL restart_zero: got %h expected %h", got, exp);
    else passCount++;
    repeat (3) tick();
    addr = 16'h8040; rdEn = 1'b1;
    tick();
    rdEn = 1'b0;
    expQ.push_back(32'd4);
    got = cycleCount | rdData; exp = expQ.pop_front(); checkCount++;
    if (got !== exp) $display("[TB] FAIL restart_count: got %h expected %h", got, exp);
    else passCount++;
  endtask

  task automatic test_back_to_back();
    store(16'h8000, 32'h00000000);
    sortStartIn = 1'b1;
    tick();
    sortStartIn = 1'b0;
    tick();
    addr = 16'h8000; wrData = 32'h1; wrEn = 1'b1;
    tick();
    wrEn = 1'b0; wrData = '0;
    expQ.push_back(32'h0000_0107);
    addr = 16'h8040; #1;
    got = cycleCount | {23'h0, rdData[0], 7'h0, sortFinished}; exp = expQ.pop_front(); checkCount++;
    if (got !== exp) $display("[TB] FAIL edge_and_finish: got %h expected %h", got, exp);
    else passCount++;
    repeat (5) tick();
    expQ.push_back(32'd7);
    got = cycleCount; exp = expQ.pop_front(); checkCount++;
    if (got !== exp) $display("[TB] FAIL done_after_tie: got %h expected %h", got, exp);
    else passCount++;
    sortStartIn = 1'b1;
    tick();
    sortStartIn = 1'b0;
    tick();
    rdEn = 1'b1;
    tick();
    rdEn = 1'b0;
    expQ.push_back(32'h1);
    got = rdData | cycleCount; exp = expQ.pop_front(); checkCount++;
    if (got !== exp) $display("[TB] FAIL edge_beats_clear: got %h expected %h", got, exp);
    else passCount++;
  endtask

  task automatic test_saturation();
    force dut.cycleCount_q = 32'hFFFFFFFD;
    #1;
    release dut.cycleCount_q;
    tick();
    expQ.push_back(32'hFFFFFFFE);
    got = cycleCount; exp = expQ.pop_front(); checkCount++;
    if (got !== exp) $display("[TB] FAIL sat_step: got %h expected %h", got, exp);
    else passCount++;
    repeat (4) tick();
    expQ.push_back(32'hFFFFFFFF);
    addr = 16'h8050; #1;
    got = rdData; exp = expQ.pop_front(); checkCount++;
    if (got !== exp) $display("[TB] FAIL saturate: got %h expected %h", got, exp);
    else passCount++;
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expQ.push_back(32'h0);
    got = cycleCount | 32'(sortFinished); exp = expQ.pop_front(); checkCount++;
    if (got !== exp) $display("[TB] FAIL reset_mid: got %h expected %h", got, exp);
    else passCount++;
    repeat (3) tick();
    sortStartIn = 1'b1;
    tick();
    sortStartIn = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    expQ.push_back(32'h0);
    addr = 16'h8040; #1;
    got = cycleCount | rdData; exp = expQ.pop_front(); checkCount++;
    if (got !== exp) $display("[TB] FAIL reset_lost_edge: got %h expected %h", got, exp);
    else passCount++;
  endtask

  initial begin
    checkCount = 0; passCount = 0;
    rst = 1'b1; addr = '0; wrEn = 1'b0; rdEn = 1'b0; wrData = '0;
    sortStartIn = 1'b0; ceIn = 1'b0; cpIn = 1'b0; chIn = 1'b0;
    test_reset();
    test_writes();
    test_sync();
    test_start();
    test_finish();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
